// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin arbiter sharing one sprite ROM among N_REQ requesters with tagged read return
module sprite_rom_arbiter #(
  parameter int N_REQ = 4,
  parameter int ADDRW = 10,
  parameter int DATAW = 3,
  parameter int ROM_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   line,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ADDRW-1:0] req_addr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rvalid,
  output logic [DATAW-1:0]       rdata,
  output logic [ADDRW-1:0]       rom_addr,
  output logic                   rom_en,
  input  logic [DATAW-1:0]       rom_data
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [PW-1:0] ptr, gidx, ptr_nxt;
  logic [ROM_LAT:0][N_REQ-1:0] tag;
  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    gidx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (req[k]) begin
        gnt = N_REQ'(1) << k;
        gidx = PW'(k);
      end
    end
    if (RESET || !en) gnt = '0;
  end
  assign ptr_nxt = line ? '0 : !(|gnt) ? ptr : gidx == PW'(N_REQ - 1) ? '0 : gidx + 1'b1;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr <= '0;
      rom_en <= 1'b0;
      rom_addr <= '0;
      tag <= '0;
    end else begin
      ptr <= ptr_nxt;
      rom_en <= |gnt;
      if (|gnt) rom_addr <= req_addr[int'(gidx)*ADDRW +: ADDRW];
      tag <= {tag[ROM_LAT-1:0], gnt};
    end
  end
  assign rvalid = tag[ROM_LAT];
  assign rdata = rom_data;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: scoreboard bench running ROM_LAT=1 and ROM_LAT=3 arbiters on shared stimulus
module tb_sprite_rom_arbiter;
  localparam int N = 4;
  localparam int AW = 10;
  localparam int DW = 3;
  typedef struct packed {
    int          due;
    logic [N-1:0] oh;
    logic [DW-1:0] d;
  } item_t;
  logic CLK = 1'b0;
  logic RESET, line, en;
  logic [N-1:0] req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0] gnt_w [2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [DW-1:0] rom_f(logic [AW-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ {2'b00, a[9]};
  endfunction
  function automatic int pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic set_addr(int i, logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask
  genvar g;
  for (g = 0; g < 2; g++) begin : lat
    localparam int L = (g == 0) ? 1 : 3;
    logic [N-1:0] rvalid;
    logic [DW-1:0] rdata, rom_data;
    logic [AW-1:0] rom_addr;
    logic rom_en;
    logic [DW-1:0] pipe [L];
    item_t q[$];
    int ptr = 0;
    logic e_en = 1'b0;
    logic [AW-1:0] e_addr = '0;
    sprite_rom_arbiter #(.N_REQ(N), .ADDRW(AW), .DATAW(DW), .ROM_LAT(L)) u_dut (
      .CLK(CLK), .RESET(RESET), .line(line), .en(en), .req(req), .req_addr(req_addr),
      .gnt(gnt_w[g]), .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr), .rom_en(rom_en),
      .rom_data(rom_data)
    );
    always @(posedge CLK) begin
      pipe[0] <= rom_f(rom_addr);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data = pipe[L-1];
    always @(negedge CLK) begin
      int k;
      logic [N-1:0] eg;
      logic [AW-1:0] a;
      item_t it;
      k = (RESET || !en) ? -1 : pick(req, ptr);
      eg = (k < 0) ? '0 : N'(1) << k;
      if (armed) begin
        chk($sformatf("gnt_L%0d", L), 32'(gnt_w[g]), 32'(eg));
        chk($sformatf("rom_en_L%0d", L), 32'(rom_en), 32'(e_en));
        chk($sformatf("rom_addr_L%0d", L), 32'(rom_addr), 32'(e_addr));
      end
      if (RESET) begin
        ptr = 0;
        e_en = 1'b0;
        e_addr = '0;
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      end else begin
        if (k >= 0) begin
          a = req_addr[k*AW +: AW];
          it.due = cyc + 1 + L;
          it.oh = eg;
          it.d = rom_f(a);
          q.push_back(it);
          ptr = (k + 1) % N;
          e_en = 1'b1;
          e_addr = a;
        end else e_en = 1'b0;
        if (line) ptr = 0;
      end
    end
    always @(negedge CLK) begin
      logic [N-1:0] ev;
      ev = (q.size() > 0 && q[0].due == cyc) ? q[0].oh : '0;
      if (armed) begin
        chk($sformatf("rvalid_L%0d", L), 32'(rvalid), 32'(ev));
        if (ev != '0) chk($sformatf("rdata_L%0d", L), 32'(rdata), 32'(q[0].d));
      end
      if (ev != '0) void'(q.pop_front());
    end
  end
  initial begin
    logic [N-1:0] gl, pend;
    RESET = 1'b1; en = 1'b0; line = 1'b0; req = '0; req_addr = '0;
    tick; tick;
    armed = 1'b1;
    RESET = 1'b0; en = 1'b1; set_addr(2, 10'h155); req = 4'b0100; tick;
    req = '0; repeat (4) tick;
    line = 1'b1; tick; line = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < N; j++) set_addr(j, 10'($urandom));
      tick;
    end
    req = 4'b0100; tick;
    req = 4'b1001; line = 1'b1; tick;
    req = 4'b0001; line = 1'b0; tick;
    req = '0; tick;
    req = 4'b1000; tick;
    en = 1'b0; req = 4'b0011; repeat (3) tick;
    en = 1'b1; tick;
    req = '0; repeat (4) tick;
    set_addr(1, 10'h2a3); set_addr(2, 10'h0f1);
    req = 4'b0010; tick;
    req = 4'b0100; tick;
    req = 4'b0110; RESET = 1'b1; tick;
    RESET = 1'b0; tick;
    req = '0; repeat (5) tick;
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      set_addr(0, 10'(i));
      tick;
    end
    req = '0; repeat (6) tick;
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      gl = gnt_w[0];
      tick;
      for (int i = 0; i < N; i++) begin
        if (gl[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          set_addr(i, 10'($urandom));
        end
      end
      req = pend;
      en = $urandom_range(9) != 0;
      line = $urandom_range(19) == 0;
      RESET = $urandom_range(99) == 0;
    end
    req = '0; en = 1'b1; line = 1'b0; RESET = 1'b0;
    repeat (8) tick;
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
